fft8_readout_seq: RTL

Sequencer for the 8-point DIT FFT datapath (`dit_fft_8`), whose output bin is chosen combinationally by a 3-bit `sel`. On `start`, the block steps `sel` through all 8 bins. For each bin it:
- waits a programmable settle time,
- captures the 9-bit real/imag result,
- presents it on a valid/ready stream to the downstream consumer.

It sits between `dit_fft_8` and any consumer (serializer, magnitude unit). Frame completion is signalled with a one-cycle `done` pulse.

---
 rtl/fft8_readout_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fft8_readout_seq.sv
// fft8_readout_seq: steps the dit_fft_8 bin select through all 8 bins,
// waits SETTLE_CYC cycles per bin, captures the real/imag result and
// presents it on a valid/ready stream. A one-cycle done pulse closes a frame.
// Optional build macro FFT8_BITREV_EN: visit bins in bit-reversed order
// (0,4,2,6,1,5,3,7) instead of natural order. Timing is the same either way.
module fft8_readout_seq #(
   parameter int DW         = 9,
   parameter int SETTLE_CYC = 2   // legal range 1..15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] fft_re,
   input  logic [DW-1:0] fft_im,
   output logic [2:0]    sel,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic [2:0]    out_idx,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_OUT    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Settle counter is 4 bits wide, enough for the full 1..15 range.
   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

   // Visiting order of the bins: k-th visited bin -> datapath select.
   function automatic logic [2:0] order(input logic [2:0] k);
`ifdef FFT8_BITREV_EN
      return {k[0], k[1], k[2]};
`else
      return k;
`endif
   endfunction

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [2:0]    k_q, k_d;
   logic [2:0]    sel_q, sel_d;
   logic [DW-1:0] out_re_q, out_re_d;
   logic [DW-1:0] out_im_q, out_im_d;
   logic [2:0]    out_idx_q, out_idx_d;
   logic          out_valid_q, out_valid_d;
   logic          done_q, done_d;

   // Next-state and registered-output computation for the readout sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      k_d         = k_q;
      sel_d       = sel_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               k_d     = 3'd0;
               sel_d   = order(3'd0);
               cnt_d   = 4'd0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               // Datapath output has settled for the current sel: capture it.
               out_re_d    = fft_re;
               out_im_d    = fft_im;
               out_idx_d   = sel_q;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_OUT: begin
            // out_valid is always high here, so ready alone completes the handshake.
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (k_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + 3'd1;
                  sel_d   = order(k_q + 3'd1);
                  cnt_d   = 4'd0;
                  state_d = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything, including a handshake in the same cycle,
      // and also swallows a pending done pulse.
      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         k_q         <= '0;
         sel_q       <= '0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         sel_q       <= sel_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign sel       = sel_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;

endmodule
